// File: rtl/keypad_scan_debounce_if.sv
// Keypad bus between the matrix scanner and its consumers.
//
// Signals:
//   key_row    4   keypad rows into the scanner; high = key in driven column pressed
//   key_col    4   one-hot active-high column drive from the scanner
//   keys       16  debounced key levels, bit k = key k held (k = 4*col + row)
//   key_press  16  one-clk pulse per key on a debounced 0->1
//   key_valid  1   one-clk pulse when key_press != 0
//   key_code   4   lowest index set in key_press, meaningful while key_valid=1
//   col_state  2   debug view of the column FSM state
//
// Handshake: key_valid/key_code/key_press form a push-only event channel.
// The scanner asserts them for exactly one clk per press event and never
// waits; there is no ready, so the consumer must take the event that cycle.
//
// Modports: master = scanner side, slave = consumer / keypad side.
interface keypad_scan_debounce_if;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [15:0] keys;
    logic [15:0] key_press;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [1:0]  col_state;

    modport master (
        input  key_row,
        output key_col, keys, key_press, key_valid, key_code, col_state
    );

    modport slave (
        output key_row,
        input  key_col, keys, key_press, key_valid, key_code, col_state
    );
endinterface

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with per-key debounce.
//
// Drives one column at a time, waits SETTLE_TICKS scan ticks, samples the
// synchronized rows, then moves to the next column. Each key flips its
// debounced level only after DEBOUNCE_SCANS consecutive samples that differ
// from the current level; a single agreeing sample restarts the count.
// A debounced 0->1 produces a one-clk press event. Releases are silent.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset, synchronous release expected
//   kp     keypad bus (master modport): key_row in; key_col, keys,
//          key_press, key_valid, key_code, col_state out
module keypad_scan_debounce #(
    parameter int CLK_DIV        = 50,
    parameter int SETTLE_TICKS   = 1,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    keypad_scan_debounce_if.master        kp
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS) + 1;

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_e;

    // ---------------- row synchronizer ----------------
    logic [3:0] row_meta_q;
    logic [3:0] row_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= '0;
            row_sync_q <= '0;
        end else begin
            row_meta_q <= kp.key_row;
            row_sync_q <= row_meta_q;
        end
    end

    // ---------------- scan tick ----------------
    logic [DW-1:0] div_q;
    logic          tick;

    assign tick = (div_q == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    // ---------------- column FSM ----------------
    col_state_e  state_q;
    logic [SW-1:0] settle_q;
    logic [3:0]  key_col_q;
    logic        sample;

    // The sampling tick is the one after the column has settled long enough.
    assign sample = tick && (settle_q == SW'(SETTLE_TICKS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COL0;
            settle_q  <= '0;
            key_col_q <= 4'b0001;
        end else if (tick) begin
            if (!sample) begin
                settle_q <= settle_q + SW'(1);
            end else begin
                settle_q  <= '0;
                key_col_q <= {key_col_q[2:0], key_col_q[3]};
                case (state_q)
                    COL0:    state_q <= COL1;
                    COL1:    state_q <= COL2;
                    COL2:    state_q <= COL3;
                    default: state_q <= COL0;
                endcase
            end
        end
    end

    // ---------------- debounce ----------------
    logic [15:0]   keys_q,  keys_d;
    logic [15:0]   press_q, press_d;
    logic          valid_q, valid_d;
    logic [3:0]    code_q,  code_d;
    logic [CW-1:0] cnt_q [16];
    logic [CW-1:0] cnt_d [16];
    logic [1:0]    col_idx;

    assign col_idx = state_q;

    function automatic logic [3:0] key_idx(input logic [1:0] c, input logic [1:0] r);
        return {c, r};
    endfunction

    // Only the four keys of the column being sampled are touched; every
    // other key keeps its level and count.
    always_comb begin
        keys_d  = keys_q;
        press_d = '0;
        cnt_d   = cnt_q;
        if (sample) begin
            for (int r = 0; r < 4; r++) begin
                if (row_sync_q[r] == keys_q[key_idx(col_idx, 2'(r))]) begin
                    cnt_d[key_idx(col_idx, 2'(r))] = '0;
                end else if (cnt_q[key_idx(col_idx, 2'(r))] == CW'(DEBOUNCE_SCANS - 1)) begin
                    keys_d[key_idx(col_idx, 2'(r))]  = row_sync_q[r];
                    press_d[key_idx(col_idx, 2'(r))] = row_sync_q[r];
                    cnt_d[key_idx(col_idx, 2'(r))]   = '0;
                end else begin
                    cnt_d[key_idx(col_idx, 2'(r))] = cnt_q[key_idx(col_idx, 2'(r))] + CW'(1);
                end
            end
        end
        valid_d = |press_d;
        // Descending scan so the lowest set index wins.
        code_d = '0;
        for (int i = 15; i >= 0; i--) begin
            if (press_d[i]) begin
                code_d = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_q  <= '0;
            press_q <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            for (int k = 0; k < 16; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            keys_q  <= keys_d;
            press_q <= press_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign kp.key_col   = key_col_q;
    assign kp.keys      = keys_q;
    assign kp.key_press = press_q;
    assign kp.key_valid = valid_q;
    assign kp.key_code  = code_q;
    assign kp.col_state = state_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
module tb_keypad_scan_debounce;

    localparam int CLK_DIV        = 4;
    localparam int SETTLE_TICKS   = 1;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int COL_PERIOD     = (SETTLE_TICKS + 1) * CLK_DIV;
    localparam int SCAN_PERIOD    = 4 * COL_PERIOD;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    keypad_scan_debounce_if kp_if ();

    keypad_scan_debounce #(
        .CLK_DIV        (CLK_DIV),
        .SETTLE_TICKS   (SETTLE_TICKS),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp_if)
    );

    // ---------------- passive keypad ----------------
    logic [15:0] pressed;

    function automatic logic [3:0] row_drive(input logic [3:0] col, input logic [15:0] p);
        logic [3:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (col[c] && p[4*c + r]) v[r] = 1'b1;
            end
        end
        return v;
    endfunction

    assign kp_if.key_row = row_drive(kp_if.key_col, pressed);

    // ---------------- checking ----------------
    int n_vec;
    int n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time-based view: n_m counts clk edges since reset release. The column
    // driven after edge n is (n / COL_PERIOD) mod 4, samples happen on every
    // edge that is a multiple of COL_PERIOD, and the sampled rows are the
    // keypad seen two edges earlier (through the synchronizer).
    int unsigned n_m;
    logic [3:0]  s1_m, s2_m;
    logic [15:0] keys_m;
    logic [15:0] press_m;
    int          run_m [16];

    always @(posedge clk or negedge rst_n) begin : ref_model
        int          col_b;
        logic [15:0] kn;
        logic [15:0] pn;
        int          rn [16];
        if (!rst_n) begin
            n_m     <= 0;
            s1_m    <= '0;
            s2_m    <= '0;
            keys_m  <= '0;
            press_m <= '0;
            for (int k = 0; k < 16; k++) run_m[k] <= 0;
        end else begin
            col_b = int'((n_m / COL_PERIOD) % 4);
            kn    = keys_m;
            pn    = '0;
            rn    = run_m;
            if (((n_m + 1) % COL_PERIOD) == 0) begin
                for (int r = 0; r < 4; r++) begin
                    int k;
                    k = 4*col_b + r;
                    if (s2_m[r] != kn[k]) begin
                        rn[k] = rn[k] + 1;
                        if (rn[k] == DEBOUNCE_SCANS) begin
                            kn[k] = s2_m[r];
                            pn[k] = s2_m[r];
                            rn[k] = 0;
                        end
                    end else begin
                        rn[k] = 0;
                    end
                end
            end
            s2_m    <= s1_m;
            s1_m    <= row_drive(4'b0001 << col_b, pressed);
            n_m     <= n_m + 1;
            keys_m  <= kn;
            press_m <= pn;
            run_m   <= rn;
        end
    end

    function automatic logic [3:0] lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Observed pulses, for per-scenario event counts.
    int valid_seen;

    always @(negedge clk) begin
        check_eq("key_col", {28'd0, kp_if.key_col}, 32'(4'b0001 << ((n_m / COL_PERIOD) % 4)));
        check_eq("keys", {16'd0, kp_if.keys}, {16'd0, keys_m});
        check_eq("key_press", {16'd0, kp_if.key_press}, {16'd0, press_m});
        check_eq("key_valid", {31'd0, kp_if.key_valid}, {31'd0, |press_m});
        if (press_m != 16'd0) begin
            check_eq("key_code", {28'd0, kp_if.key_code}, {28'd0, lowest(press_m)});
        end
        if (kp_if.key_valid) valid_seen++;
    end

    // ---------------- driver tasks ----------------
    task automatic hold(input logic [15:0] p, input int cycles);
        pressed = p;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec      = 0;
        n_err      = 0;
        valid_seen = 0;
        pressed    = '0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_col", {28'd0, kp_if.key_col}, 32'h1);
        check_eq("reset_keys", {16'd0, kp_if.keys}, 32'h0);
        rst_n = 1'b1;

        // 1: idle scanning, no keys
        hold(16'h0000, SCAN_PERIOD + 8);
        check_eq("idle_no_valid", valid_seen, 0);

        // 2: key 9 held steady
        valid_seen = 0;
        hold(16'h0200, 4*SCAN_PERIOD);
        check_eq("k9_keys", {16'd0, kp_if.keys}, 32'h0200);
        check_eq("k9_one_pulse", valid_seen, 1);

        // 4: release key 9
        valid_seen = 0;
        hold(16'h0000, 4*SCAN_PERIOD);
        check_eq("k9_released", {16'd0, kp_if.keys}, 32'h0);
        check_eq("release_silent", valid_seen, 0);

        // 3: bounce high 2 scans, low 1, high 2 -> no press
        valid_seen = 0;
        hold(16'h0200, 2*SCAN_PERIOD);
        hold(16'h0000, SCAN_PERIOD);
        hold(16'h0200, 2*SCAN_PERIOD);
        check_eq("bounce_keys", {16'd0, kp_if.keys}, 32'h0);
        check_eq("bounce_no_pulse", valid_seen, 0);
        hold(16'h0200, 2*SCAN_PERIOD);
        check_eq("bounce_then_press", {16'd0, kp_if.keys}, 32'h0200);
        hold(16'h0000, 4*SCAN_PERIOD);

        // 5: keys 4 and 7 together
        valid_seen = 0;
        hold(16'h0090, 4*SCAN_PERIOD);
        check_eq("k47_keys", {16'd0, kp_if.keys}, 32'h0090);
        check_eq("k47_one_pulse", valid_seen, 1);
        hold(16'h0000, 4*SCAN_PERIOD);

        // 6: reset mid-debounce
        do_reset();
        pressed = 16'h0200;
        for (int i = 0; i < 8*SCAN_PERIOD && run_m[9] != 2; i++) @(negedge clk);
        check_eq("k9_count2_reached", run_m[9], 2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_col", {28'd0, kp_if.key_col}, 32'h1);
        check_eq("async_keys", {16'd0, kp_if.keys}, 32'h0);
        check_eq("async_press", {16'd0, kp_if.key_press}, 32'h0);
        check_eq("async_valid", {31'd0, kp_if.key_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        valid_seen = 0;
        hold(16'h0200, 2*SCAN_PERIOD);
        check_eq("fresh_not_yet", {16'd0, kp_if.keys}, 32'h0);
        check_eq("fresh_no_pulse", valid_seen, 0);
        hold(16'h0200, 2*SCAN_PERIOD);
        check_eq("fresh_pressed", {16'd0, kp_if.keys}, 32'h0200);

        // random keypad activity
        for (int s = 0; s < 30; s++) begin
            logic [15:0] p;
            p = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) p = '0;
            hold(p, $urandom_range(6, 4*SCAN_PERIOD));
        end
        hold(16'h0000, 4*SCAN_PERIOD);
        check_eq("final_keys", {16'd0, kp_if.keys}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
